// File: rtl/sf_anim_pkg.sv
// Shared types and constants for the fighter animation sequencer.
package sf_anim_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WALK_A,
    ST_WALK_B,
    ST_P_WIND,
    ST_P_EXT,
    ST_P_REC,
    ST_K_WIND,
    ST_K_EXT,
    ST_HIT
  } anim_state_t;

  localparam logic [2:0] SPR_IDLE   = 3'd0;
  localparam logic [2:0] SPR_WALK_A = 3'd1;
  localparam logic [2:0] SPR_WALK_B = 3'd2;
  localparam logic [2:0] SPR_WIND_P = 3'd3;
  localparam logic [2:0] SPR_EXT_P  = 3'd4;
  localparam logic [2:0] SPR_WIND_K = 3'd5;
  localparam logic [2:0] SPR_EXT_K  = 3'd6;
  localparam logic [2:0] SPR_HIT    = 3'd7;

  localparam logic [1:0] ACT_IDLE  = 2'd0;
  localparam logic [1:0] ACT_WALK  = 2'd1;
  localparam logic [1:0] ACT_PUNCH = 2'd2;
  localparam logic [1:0] ACT_KICK  = 2'd3;

  // Sprite ROM index for a state; punch recovery reuses the windup frame.
  // Also used by the color-mapper debug overlay.
  function automatic logic [2:0] state_to_sprite(input anim_state_t s);
    case (s)
      ST_IDLE:   return SPR_IDLE;
      ST_WALK_A: return SPR_WALK_A;
      ST_WALK_B: return SPR_WALK_B;
      ST_P_WIND: return SPR_WIND_P;
      ST_P_EXT:  return SPR_EXT_P;
      ST_P_REC:  return SPR_WIND_P;
      ST_K_WIND: return SPR_WIND_K;
      ST_K_EXT:  return SPR_EXT_K;
      ST_HIT:    return SPR_HIT;
      default:   return SPR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/anim_hold_timer.sv
// Frame-tick hold counter: counts ticks since the last clear and flags the
// tick on which the programmed hold length is reached.
module anim_hold_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick,
  input  logic [4:0] hold,
  output logic       expire
);

  logic [4:0] count;

  // Clear wins over tick so a state entry always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= 5'd0;
    else if (clr)  count <= 5'd0;
    else if (tick) count <= count + 5'd1;
  end

  // Expiry is qualified by tick so the state only advances on a frame tick.
  always_comb begin
    expire = tick & (count == (hold - 5'd1));
  end

endmodule

// File: rtl/fighter_anim_ctrl.sv
// Per-fighter animation sequencer: accepts action commands and hits, steps
// timed animation states on frame ticks and drives the sprite ROM index plus
// the attack window/start signals used by the damage logic.
module fighter_anim_ctrl
  import sf_anim_pkg::*;
#(
  parameter int HOLD_WALK = 8,
  parameter int HOLD_WIND = 4,
  parameter int HOLD_EXT  = 6,
  parameter int HOLD_REC  = 4,
  parameter int HOLD_HIT  = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       action_valid,
  input  logic [1:0] action_code,
  output logic       action_ready,
  input  logic       hit,
  output logic [2:0] sprite,
  output logic       attack_active,
  output logic       attack_start,
  output logic       in_hitstun
);

  anim_state_t state, state_nx;
  logic        accept;
  logic        clr;
  logic        expire;
  logic [4:0]  hold;
  logic [2:0]  sprite_d;
  logic        active_d, start_d, hitstun_d;

  // Hold length for the current state; IDLE never uses its expiry.
  always_comb begin
    case (state)
      ST_WALK_A, ST_WALK_B: hold = 5'(HOLD_WALK);
      ST_P_WIND, ST_K_WIND: hold = 5'(HOLD_WIND);
      ST_P_EXT,  ST_K_EXT:  hold = 5'(HOLD_EXT);
      ST_P_REC:             hold = 5'(HOLD_REC);
      ST_HIT:               hold = 5'(HOLD_HIT);
      default:              hold = 5'd0;
    endcase
  end

  anim_hold_timer u_timer (
    .clk    (Clk),
    .rst    (Reset),
    .clr    (clr),
    .tick   (frame_tick),
    .hold   (hold),
    .expire (expire)
  );

  // Commands are only taken in the interruptible states and never alongside a hit.
  always_comb begin
    action_ready = ((state == ST_IDLE) || (state == ST_WALK_A) || (state == ST_WALK_B)) & ~hit;
    accept       = action_valid & action_ready;
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: hit first, then commands, then timed expiry.
  always_comb begin
    state_nx = state;
    if (hit) begin
      state_nx = ST_HIT;
    end else begin
      case (state)
        ST_IDLE, ST_WALK_A, ST_WALK_B: begin
          if (accept) begin
            case (action_code)
              ACT_IDLE:  state_nx = ST_IDLE;
              ACT_WALK:  state_nx = (state == ST_IDLE) ? ST_WALK_A : state;
              ACT_PUNCH: state_nx = ST_P_WIND;
              default:   state_nx = ST_K_WIND;
            endcase
          end else if (expire && state == ST_WALK_A) begin
            state_nx = ST_WALK_B;
          end else if (expire && state == ST_WALK_B) begin
            state_nx = ST_WALK_A;
          end
        end
        ST_P_WIND: if (expire) state_nx = ST_P_EXT;
        ST_P_EXT:  if (expire) state_nx = ST_P_REC;
        ST_P_REC:  if (expire) state_nx = ST_IDLE;
        ST_K_WIND: if (expire) state_nx = ST_K_EXT;
        ST_K_EXT:  if (expire) state_nx = ST_IDLE;
        ST_HIT:    if (expire) state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
    // A hit re-enters HIT even from HIT, so hitstun restarts from zero.
    clr = hit | (state_nx != state);
  end

  // Output decode from the upcoming state so registered outputs track the transition edge.
  always_comb begin
    sprite_d  = state_to_sprite(state_nx);
    active_d  = (state_nx == ST_P_EXT) || (state_nx == ST_K_EXT);
    start_d   = active_d && (state_nx != state);
    hitstun_d = (state_nx == ST_HIT);
  end

  // Output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sprite        <= SPR_IDLE;
      attack_active <= 1'b0;
      attack_start  <= 1'b0;
      in_hitstun    <= 1'b0;
    end else begin
      sprite        <= sprite_d;
      attack_active <= active_d;
      attack_start  <= start_d;
      in_hitstun    <= hitstun_d;
    end
  end

endmodule
